// File: rtl/hqam16_mapper_pkg.sv
// Shared constants and FSM state type for the hierarchical 16-QAM mapper.
package hqam_pkg;

    localparam int SC16_W = 32;

    // Nibble bit positions: HP signs on top, LP inner/outer selects below.
    localparam int HP_I = 3;
    localparam int HP_Q = 2;
    localparam int LP_I = 1;
    localparam int LP_Q = 0;

    localparam logic [15:0] AMP_MAX = 16'h7FFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYM0 = 2'd1,
        ST_SYM1 = 2'd2
    } state_t;

endpackage

// File: rtl/hqam16_mapper_if.sv
// AXI-Stream style handshake bundle used for both the byte input and the sample output.
interface hqam16_mapper_if #(
    parameter int DW = 8
) ();
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface

// File: rtl/hqam16_mapper_sym_calc.sv
// Combinational nibble-to-IQ mapping: saturated outer level, clamped inner level, signed output.
module hqam_sym_calc
    import hqam_pkg::*;
#(
    parameter int AMP_W = 16
) (
    input  logic        [3:0]       nib,
    input  logic        [AMP_W-2:0] d1,
    input  logic        [AMP_W-2:0] d2,
    output logic signed [AMP_W-1:0] i_amp,
    output logic signed [AMP_W-1:0] q_amp
);

    localparam logic [AMP_W:0] SAT_LIM = {2'b00, {(AMP_W-1){1'b1}}};

    logic [AMP_W-2:0] outer_mag;
    logic [AMP_W-2:0] inner_mag;

    function automatic logic [AMP_W-2:0] sat_outer(input logic [AMP_W-2:0] a,
                                                   input logic [AMP_W-2:0] b);
        logic [AMP_W:0] sum;
        sum = {2'b00, a} + {2'b00, b};
        if (sum > SAT_LIM)
            return {(AMP_W-1){1'b1}};
        return sum[AMP_W-2:0];
    endfunction

    function automatic logic [AMP_W-2:0] clamp_inner(input logic [AMP_W-2:0] a,
                                                     input logic [AMP_W-2:0] b);
        if (b > a)
            return '0;
        return a - b;
    endfunction

    // Magnitude never exceeds 0x7FFF, so negation cannot reach 0x8000.
    function automatic logic signed [AMP_W-1:0] apply_sign(input logic neg,
                                                           input logic [AMP_W-2:0] mag);
        logic signed [AMP_W-1:0] m;
        m = signed'({1'b0, mag});
        return neg ? -m : m;
    endfunction

    always_comb begin
        outer_mag = sat_outer(d1, d2);
        inner_mag = clamp_inner(d1, d2);
        i_amp     = apply_sign(nib[HP_I], nib[LP_I] ? inner_mag : outer_mag);
        q_amp     = apply_sign(nib[HP_Q], nib[LP_Q] ? inner_mag : outer_mag);
    end

endmodule

// File: rtl/hqam16_mapper.sv
// Hierarchical 16-QAM mapper: one coded byte in, two registered sc16 samples out.
module hqam16_mapper
    import hqam_pkg::*;
#(
    parameter int AMP_W = 16
) (
    input  logic             ce_clk,
    input  logic             ce_rst,
    input  logic [AMP_W-2:0] cfg_d1,
    input  logic [AMP_W-2:0] cfg_d2,
    input  logic             cfg_lsn_first,
    hqam16_mapper_if.slave   s_axis,
    hqam16_mapper_if.master  m_axis,
    output logic [31:0]      sym_count
);

    state_t state_q;

    logic [7:0]       byte_p0;
    logic [AMP_W-2:0] d1_p0;
    logic [AMP_W-2:0] d2_p0;
    logic             lsn_p0;
    logic             last_p0;

    logic [3:0]       nib_sel;
    logic [AMP_W-2:0] d1_sel;
    logic [AMP_W-2:0] d2_sel;

    logic signed [AMP_W-1:0] i_calc;
    logic signed [AMP_W-1:0] q_calc;

    logic [2*AMP_W-1:0] data_p1;
    logic               last_p1;
    logic               vld_p1;
    logic [31:0]        cnt_q;

    logic s_rdy;
    logic in_acc;
    logic out_acc;

    always_comb begin
        s_rdy = 1'b0;
        if (!ce_rst)
            s_rdy = (state_q == ST_IDLE) || ((state_q == ST_SYM1) && m_axis.tready);
    end

    assign in_acc  = s_axis.tvalid & s_rdy;
    assign out_acc = vld_p1 & m_axis.tready;

    // A byte being accepted maps its first nibble straight from the port;
    // otherwise the held byte supplies the second nibble with its captured config.
    always_comb begin
        nib_sel = '0;
        d1_sel  = d1_p0;
        d2_sel  = d2_p0;
        if (in_acc) begin
            nib_sel = cfg_lsn_first ? s_axis.tdata[3:0] : s_axis.tdata[7:4];
            d1_sel  = cfg_d1;
            d2_sel  = cfg_d2;
        end else begin
            nib_sel = lsn_p0 ? byte_p0[7:4] : byte_p0[3:0];
        end
    end

    hqam_sym_calc #(.AMP_W(AMP_W)) u_sym_calc (
        .nib   (nib_sel),
        .d1    (d1_sel),
        .d2    (d2_sel),
        .i_amp (i_calc),
        .q_amp (q_calc)
    );

    // Stage p0: byte, tlast and config held for the second symbol
    always_ff @(posedge ce_clk) begin
        if (in_acc) begin
            byte_p0 <= s_axis.tdata;
            last_p0 <= s_axis.tlast;
            d1_p0   <= cfg_d1;
            d2_p0   <= cfg_d2;
            lsn_p0  <= cfg_lsn_first;
        end
    end

    // Stage p1: FSM, output sample register and symbol counter
    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            state_q <= ST_IDLE;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (out_acc)
                cnt_q <= cnt_q + 32'd1;
            unique case (state_q)
                ST_IDLE: begin
                    if (in_acc) begin
                        data_p1 <= {i_calc, q_calc};
                        last_p1 <= 1'b0;
                        vld_p1  <= 1'b1;
                        state_q <= ST_SYM0;
                    end
                end
                ST_SYM0: begin
                    if (out_acc) begin
                        data_p1 <= {i_calc, q_calc};
                        last_p1 <= last_p0;
                        state_q <= ST_SYM1;
                    end
                end
                ST_SYM1: begin
                    if (out_acc) begin
                        if (in_acc) begin
                            data_p1 <= {i_calc, q_calc};
                            last_p1 <= 1'b0;
                            state_q <= ST_SYM0;
                        end else begin
                            vld_p1  <= 1'b0;
                            last_p1 <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    vld_p1  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis.tready = s_rdy;
    assign m_axis.tdata  = data_p1;
    assign m_axis.tlast  = last_p1;
    assign m_axis.tvalid = vld_p1;
    assign sym_count     = cnt_q;

endmodule

// File: doc/hqam16_mapper.md
# hqam16_mapper

Hierarchical 16-QAM symbol mapper that sits directly downstream of the rate-1/2 convolutional encoder stage in the capstone RFNoC chain. It consumes the encoder's 8-bit coded-byte AXI-Stream, splits each byte into two 4-bit symbols, and emits one sc16 IQ sample per symbol. It uses run-time high-priority/low-priority spacing (D1/D2) and saturating arithmetic. It runs in the block's `ce_clk` domain between the NoC shell payload ports.

## Interface
Parameters:
- `AMP_W`, 16: width of each I/Q component; output word is 2*AMP_W.

Ports:
- `ce_clk`  in  1: the block's single clock.
- `ce_rst`  in  1: synchronous, active-high reset.
- `cfg_d1`  in  AMP_W-1: HP half-spacing, unsigned.
- `cfg_d2`  in  AMP_W-1: LP offset, unsigned.
- `cfg_lsn_first`  in  1: 0 = bits [7:4] mapped first; 1 = bits [3:0] mapped first.
- `s_axis_tdata`  in  8: coded byte.
- `s_axis_tlast`  in  1: last byte of packet.
- `s_axis_tvalid`  in  1: input valid.
- `s_axis_tready`  out  1: input ready.
- `m_axis_tdata`  out  2*AMP_W: sc16 sample, I in [31:16], Q in [15:0].
- `m_axis_tlast`  out  1: last sample of packet.
- `m_axis_tvalid`  out  1: output valid.
- `m_axis_tready`  in  1: output ready.
- `sym_count`  out  32: count of symbols transferred since reset; wraps from 0xFFFFFFFF to 0.

## Operation
- Nibble mapping uses n[3:0]:
  - n[3] is the HP I sign and n[2] is the HP Q sign (0 = +, 1 = −).
  - n[1] is the LP I bit and n[0] is the LP Q bit.
- Magnitude per axis: LP bit 0 → outer = D1+D2; LP bit 1 → inner = D1−D2.
- Width rules:
  - Outer is computed at AMP_W+1 bits and saturates to 2^(AMP_W−1)−1 (0x7FFF).
  - Inner clamps to 0 when D2 > D1.
  - Negation is two's complement of the saturated magnitude, so the minimum output is −0x7FFF. 0x8000 is never produced.
- `cfg_d1`, `cfg_d2` and `cfg_lsn_first` are captured when a byte is accepted. Both symbols of a byte use the same config, and changes mid-byte have no effect until the next byte.
- FSM states:
  - IDLE: no symbol held.
  - SYM0: first symbol presented; second pending.
  - SYM1: second symbol presented.
- FSM transitions:
  - IDLE → SYM0 on input accept.
  - SYM0 → SYM1 on output accept.
  - SYM1 → SYM0 on output accept with a simultaneous input accept.
  - SYM1 → IDLE on output accept with no input accept.
- `s_axis_tready` = (state==IDLE) or (state==SYM1 and m_axis_tready). It is forced 0 while `ce_rst` is high.
- The input `tlast` is stored with the byte and asserted on the second symbol only. The first symbol always has tlast=0.
- `sym_count` increments on every m_axis handshake (tvalid & tready).

## Timing
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0.
  - `s_axis_tready`=0 during reset, 1 on the first cycle after reset.
  - `sym_count`=0; state=IDLE.
- Output is fully registered. A byte accepted at edge N presents symbol 0 at N+1; symbol 1 is presented at N+2 at the earliest.
- Sustained throughput is one sample per cycle (one byte per 2 cycles) with `m_axis_tready` held high.
- While `m_axis_tvalid`=1 and `m_axis_tready`=0, `m_axis_tdata` and `m_axis_tlast` are held stable.
- `m_axis_tvalid` never drops without a handshake.
- Reset asserted mid-operation discards any held byte and symbols; no partial sample is emitted after reset.
- There is no combinational path from `s_axis_tvalid` to `m_axis_tvalid`. The only combinational path from `m_axis_tready` is to `s_axis_tready`.

## Structure
- Shared package `hqam_pkg`:
  - Constants: `SC16_W`=32, nibble bit positions (HP_I=3, HP_Q=2, LP_I=1, LP_Q=0), `AMP_MAX`=0x7FFF.
  - Enum for the FSM states.
- Sub-module `hqam_sym_calc`: combinational mapping of nibble + D1 + D2 to {I,Q}, including saturation and clamp. It is instantiated once and muxed by the selected nibble.
- Top level holds the byte/config/tlast register, FSM, output register and counter.

## Test plan
- **Basic mapping:** D1=0x3000, D2=0x1000, lsn_first=0, byte 0xF5 with tlast=1.
  - Expect 0xE000E000 (tlast=0), then 0x4000E000 (tlast=1).
- **Zero byte:** byte 0x00 → two samples 0x40004000; `sym_count`=2.
- **Saturation and clamp:**
  - D1=0x7000, D2=0x2000, byte 0x00 → 0x7FFF7FFF.
  - Same config, byte 0xCC → 0x80018001 twice.
  - D1=0x1000, D2=0x2000, byte 0x33 → 0x00000000 twice.
- **Throughput:** 4 back-to-back bytes, tlast on the 4th, `m_axis_tready`=1.
  - Expect 8 samples on 8 consecutive cycles; tlast only on the 8th.
  - `s_axis_tready` pattern alternates 1/0 after the first accept.
- **Backpressure and config change:** `m_axis_tready` low for 5 cycles in SYM0, with `cfg_d2` changed during the stall.
  - Data held stable and `s_axis_tready`=0.
  - The second symbol uses the old D2.
- **Reset and wrap:**
  - `ce_rst` pulsed in SYM1 → next cycle tvalid=0 and `sym_count`=0; the next byte maps normally.
  - Force `sym_count` to 0xFFFFFFFF, then one handshake → `sym_count`=0.
